// File: rtl/sti_pkg.sv
// sti_pkg: shared types for the STI serial receive path (FSM states, length codes, FIFO entry)
package sti_pkg;

    typedef enum logic [1:0] {IDLE, RECV, FIN} rx_state_t;

    localparam logic [1:0] LEN_8  = 2'd0;
    localparam logic [1:0] LEN_16 = 2'd1;
    localparam logic [1:0] LEN_24 = 2'd2;
    localparam logic [1:0] LEN_32 = 2'd3;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  len;
        logic        err;
    } rx_entry_t;

endpackage

// File: rtl/sti_rx_deframer_if.sv
// sti_rx_deframer_if: valid/ready parallel port carrying rebuilt frames to the consumer
interface sti_rx_deframer_if;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic [1:0]  rx_len;
    logic        rx_err;

    modport master (output rx_valid, rx_data, rx_len, rx_err, input rx_ready);
    modport slave  (input rx_valid, rx_data, rx_len, rx_err, output rx_ready);
endinterface

// File: rtl/sti_rx_fifo.sv
// sti_rx_fifo: DEPTH-entry synchronous FIFO of frame entries; a pop frees room for a same-cycle push
module sti_rx_fifo
    import sti_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  logic      pop,
    input  rx_entry_t din,
    output rx_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rx_entry_t       mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [AW:0]     cnt;
    logic            wr, rd;

    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[rp];

    // storage, pointers and occupancy; memory is cleared so the head reads 0 out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (rd) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

endmodule

// File: rtl/sti_rx_deframer.sv
// sti_rx_deframer: rebuilds serial frames into right-aligned words; STI_RX_CHKSUM_EN adds a byte checksum
module sti_rx_deframer
    import sti_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_BITS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              so_data,
    input  logic              so_valid,
    input  logic              oem_finish,
    sti_rx_deframer_if.master rx,
    output logic              ovf,
    output logic              done
`ifdef STI_RX_CHKSUM_EN
    ,
    output logic [7:0]        chksum
`endif
);
    localparam logic [5:0] SAT = 6'(MAX_BITS + 1);

    rx_state_t   state;
    logic [5:0]  cnt;
    logic [31:0] sh, mask;
    logic        fin_l, close, pop, full, empty, err;
    logic [1:0]  len;
    rx_entry_t   entry, head;

    assign close = (state == RECV) && !so_valid;
    assign pop   = !empty && rx.rx_ready;
    assign mask  = (cnt >= 6'd32) ? '1 : (32'd1 << cnt) - 32'd1;
    assign entry = '{data: sh & mask, len: len, err: err};

    // length code and error flag from the bit count at frame close
    always_comb begin
        err = 1'b0;
        len = LEN_8;
        case (cnt)
            6'd8:    len = LEN_8;
            6'd16:   len = LEN_16;
            6'd24:   len = LEN_24;
            6'd32:   len = LEN_32;
            default: begin
                err = 1'b1;
                len = (cnt == SAT) ? LEN_32 : LEN_8;
            end
        endcase
    end

    // receive FSM: shift in bits, count with saturation, latch end-of-stream, sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            fin_l <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            fin_l <= fin_l | oem_finish;
            if (close && full && !pop) ovf <= 1'b1;
            case (state)
                IDLE: begin
                    if (so_valid) begin
                        state <= RECV;
                        sh    <= {sh[30:0], so_data};
                        cnt   <= 6'd1;
                    end else if (fin_l) begin
                        state <= FIN;
                    end
                end
                RECV: begin
                    if (so_valid) begin
                        sh  <= {sh[30:0], so_data};
                        cnt <= (cnt == SAT) ? cnt : cnt + 6'd1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    sti_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (close),
        .pop     (pop),
        .din     (entry),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    assign rx.rx_valid = !empty;
    assign rx.rx_data  = head.data;
    assign rx.rx_len   = head.len;
    assign rx.rx_err   = head.err;
    assign done        = (state == FIN) && empty;

`ifdef STI_RX_CHKSUM_EN
    // running byte sum of every accepted good frame; no pushes happen once done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chksum <= '0;
        else if (close && !err && (!full || pop) && !done)
            chksum <= chksum + entry.data[31:24] + entry.data[23:16] + entry.data[15:8] + entry.data[7:0];
    end
`endif

endmodule

// File: tb/tb_sti_rx_deframer.sv
// tb_sti_rx_deframer: directed self-checking bench for sti_rx_deframer
module tb_sti_rx_deframer;
    logic clk = 1'b0;
    logic reset_n, so_data, so_valid, oem_finish, ovf, done;
`ifdef STI_RX_CHKSUM_EN
    logic [7:0] chksum;
`endif
    int errors = 0;
    int checks = 0;

    sti_rx_deframer_if rx_if ();

    sti_rx_deframer #(.DEPTH(2), .MAX_BITS(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .so_data    (so_data),
        .so_valid   (so_valid),
        .oem_finish (oem_finish),
        .rx         (rx_if),
        .ovf        (ovf),
        .done       (done)
`ifdef STI_RX_CHKSUM_EN
        ,
        .chksum     (chksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            so_valid = 1'b1;
            so_data  = v[i];
            tick();
        end
        so_valid = 1'b0;
        so_data  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_if.rx_valid); end
        checks++; if (rx_if.rx_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rx_if.rx_data); end
        checks++; if (rx_if.rx_len !== 2'd0 || rx_if.rx_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %0d/%b want 0/0", rx_if.rx_len, rx_if.rx_err); end
        checks++; if (ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ovf_done: got %b/%b want 0/0", ovf, done); end
`ifdef STI_RX_CHKSUM_EN
        checks++; if (chksum !== 8'h0) begin errors++; $display("FAIL reset_chksum: got %h want 0", chksum); end
`endif
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_byte();
        rx_if.rx_ready = 1'b1;
        send(64'hA5, 8);
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL byte_close_valid: got %b want 0", rx_if.rx_valid); end
        tick();
        checks++; if (rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL byte_valid: got %b want 1", rx_if.rx_valid); end
        checks++; if (rx_if.rx_data !== 32'h000000A5) begin errors++; $display("FAIL byte_data: got %h want 000000a5", rx_if.rx_data); end
        checks++; if (rx_if.rx_len !== 2'd0 || rx_if.rx_err !== 1'b0) begin errors++; $display("FAIL byte_len_err: got %0d/%b want 0/0", rx_if.rx_len, rx_if.rx_err); end
        tick();
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL byte_one_cycle: got %b want 0", rx_if.rx_valid); end
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        send(64'hDEADBEEF, 32);
        tick();
        send(64'h1234, 16);
        tick();
        checks++; if (rx_if.rx_data !== 32'hDEADBEEF || rx_if.rx_len !== 2'd3 || rx_if.rx_err !== 1'b0) begin errors++; $display("FAIL b2b_first: got %h/%0d/%b want deadbeef/3/0", rx_if.rx_data, rx_if.rx_len, rx_if.rx_err); end
        rx_if.rx_ready = 1'b1;
        tick();
        checks++; if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 32'h00001234 || rx_if.rx_len !== 2'd1) begin errors++; $display("FAIL b2b_second: got %b/%h/%0d want 1/00001234/1", rx_if.rx_valid, rx_if.rx_data, rx_if.rx_len); end
        tick();
        rx_if.rx_ready = 1'b0;
        checks++; if (rx_if.rx_valid !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL b2b_drained: got valid=%b ovf=%b want 0/0", rx_if.rx_valid, ovf); end
    endtask

    task automatic test_err();
        send(64'hABC, 12);
        tick();
        checks++; if (rx_if.rx_data !== 32'h00000ABC || rx_if.rx_len !== 2'd0 || rx_if.rx_err !== 1'b1) begin errors++; $display("FAIL err_short: got %h/%0d/%b want 00000abc/0/1", rx_if.rx_data, rx_if.rx_len, rx_if.rx_err); end
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        send(64'h3_1234_5678, 34);
        tick();
        checks++; if (rx_if.rx_data !== 32'h12345678 || rx_if.rx_len !== 2'd3 || rx_if.rx_err !== 1'b1) begin errors++; $display("FAIL err_long: got %h/%0d/%b want 12345678/3/1", rx_if.rx_data, rx_if.rx_len, rx_if.rx_err); end
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL err_drained: got %b want 0", rx_if.rx_valid); end
    endtask

    task automatic test_overflow();
        send(64'h11, 8);
        tick();
        send(64'h22, 8);
        tick();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf); end
        send(64'h33, 8);
        tick();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
        checks++; if (rx_if.rx_data !== 32'h11) begin errors++; $display("FAIL ovf_head_hold: got %h want 00000011", rx_if.rx_data); end
        tick();
        checks++; if (rx_if.rx_data !== 32'h11 || rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL ovf_head_stable: got %h/%b want 00000011/1", rx_if.rx_data, rx_if.rx_valid); end
        rx_if.rx_ready = 1'b1;
        tick();
        checks++; if (rx_if.rx_data !== 32'h22 || rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL ovf_second: got %h/%b want 00000022/1", rx_if.rx_data, rx_if.rx_valid); end
        tick();
        rx_if.rx_ready = 1'b0;
        checks++; if (rx_if.rx_valid !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_drained: got valid=%b ovf=%b want 0/1", rx_if.rx_valid, ovf); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v = 8'hF3;
        for (int i = 7; i >= 3; i--) begin
            so_valid = 1'b1;
            so_data  = v[i];
            tick();
        end
        so_valid = 1'b0;
        so_data  = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++; if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 32'h0 || ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got %b/%h/%b/%b want 0/0/0/0", rx_if.rx_valid, rx_if.rx_data, ovf, done); end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_entry: got %b want 0 (cycle %0d)", rx_if.rx_valid, i); end
        end
        send(64'h5A, 8);
        tick();
        checks++; if (rx_if.rx_data !== 32'h5A || rx_if.rx_len !== 2'd0 || rx_if.rx_err !== 1'b0 || rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL midreset_next: got %h/%0d/%b/%b want 0000005a/0/0/1", rx_if.rx_data, rx_if.rx_len, rx_if.rx_err, rx_if.rx_valid); end
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic test_finish();
        logic [23:0] fv = 24'hC0FFEE;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 23; i >= 0; i--) begin
            so_valid = 1'b1;
            so_data  = fv[i];
            if (i == 13) oem_finish = 1'b1;
            tick();
        end
        so_valid = 1'b0;
        so_data  = 1'b0;
        tick();
        checks++; if (rx_if.rx_data !== 32'h00C0FFEE || rx_if.rx_len !== 2'd2 || rx_if.rx_err !== 1'b0) begin errors++; $display("FAIL fin_frame: got %h/%0d/%b want 00c0ffee/2/0", rx_if.rx_data, rx_if.rx_len, rx_if.rx_err); end
        tick();
        tick();
        checks++; if (done !== 1'b0 || rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL fin_before_pop: got done=%b valid=%b want 0/1", done, rx_if.rx_valid); end
`ifdef STI_RX_CHKSUM_EN
        checks++; if (chksum !== 8'hAD) begin errors++; $display("FAIL fin_chksum: got %h want ad", chksum); end
`endif
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        checks++; if (done !== 1'b1 || rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL fin_done: got done=%b valid=%b want 1/0", done, rx_if.rx_valid); end
        send(64'hFF, 8);
        tick();
        tick();
        checks++; if (done !== 1'b1 || rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL fin_ignore: got done=%b valid=%b want 1/0", done, rx_if.rx_valid); end
`ifdef STI_RX_CHKSUM_EN
        checks++; if (chksum !== 8'hAD) begin errors++; $display("FAIL fin_chksum_frozen: got %h want ad", chksum); end
`endif
    endtask

    initial begin
        reset_n        = 1'b0;
        so_data        = 1'b0;
        so_valid       = 1'b0;
        oem_finish     = 1'b0;
        rx_if.rx_ready = 1'b0;
        test_reset();
        test_byte();
        test_back_to_back();
        test_err();
        test_overflow();
        test_reset_midframe();
        test_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
